// File: rtl/run_length_detector.sv
// Serial run-length detector: flags when a run of identical bits reaches RUN_LEN,
// with polarity filtering by mode. Optional event counter behind `RUN_DET_EVT_COUNT_EN.
module run_length_detector #(
  parameter int RUN_LEN = 2,
  parameter int MAX_RUN = 255,
  parameter int CNT_W   = $clog2(MAX_RUN + 1),
  parameter int EVT_W   = 8
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic [1:0]       mode,
  input  logic             clear,
  output logic             out_bit,
  output logic             det_pulse,
  output logic             run_val,
`ifdef RUN_DET_EVT_COUNT_EN
  output logic [EVT_W-1:0] evt_count,
`endif
  output logic [CNT_W-1:0] run_count
);

  if (RUN_LEN < 2 || RUN_LEN > MAX_RUN) begin : g_bad_run_len
    $error("run_length_detector: RUN_LEN must lie in 2..MAX_RUN");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] MAX_RUN_C = CNT_W'(MAX_RUN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             val_q, val_d;
  logic             det_q, det_d;

  function automatic logic mode_permits(input logic [1:0] m, input logic v);
    case (m)
      2'b00:   return 1'b1;
      2'b01:   return ~v;
      2'b10:   return v;
      default: return 1'b0;
    endcase
  endfunction

  // NOTE: every next-state signal gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    val_d   = val_q;
    det_d   = 1'b0;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (in_valid) begin
      if (state_q == IDLE || in_bit != val_q) begin
        val_d   = in_bit;
        count_d = ONE_C;
        state_d = RUN;
      end else begin
        if (count_q != MAX_RUN_C) count_d = count_q + ONE_C;
        // Only the RUN->HIT transition pulses, so saturation never re-triggers.
        if (state_q == RUN && count_d == RUN_LEN_C) begin
          state_d = HIT;
          det_d   = mode_permits(mode, val_q);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      val_q   <= 1'b0;
      det_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      val_q   <= val_d;
      det_q   <= det_d;
    end
  end

`ifdef RUN_DET_EVT_COUNT_EN
  logic [EVT_W-1:0] evt_q;

  // Counts alongside the registered pulse; clear deliberately leaves it alone.
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n)   evt_q <= '0;
    else if (det_d) evt_q <= evt_q + EVT_W'(1);
  end

  assign evt_count = evt_q;
`endif

  // Mode gates the registered state combinationally so it can change mid-run.
  assign out_bit   = (state_q == HIT) && mode_permits(mode, val_q);
  assign det_pulse = det_q;
  assign run_val   = val_q;
  assign run_count = count_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Self-checking bench: three detector configurations driven in parallel and compared
// every cycle against a run-length model, plus directed literal expectations.
module tb_run_length_detector;

  localparam int N = 3;
  localparam int RL[N] = '{2, 3, 2};
  localparam int MR[N] = '{255, 255, 7};

  logic       clk_2 = 1'b0;
  logic       reset_n, in_valid, in_bit, clear;
  logic [1:0] mode;
  logic       out_bit[N], det_pulse[N], run_val[N];
  logic [7:0] cnt0, cnt1;
  logic [2:0] cnt2;
  logic [7:0] cnt_all[N];
`ifdef RUN_DET_EVT_COUNT_EN
  logic [7:0] evt[N];
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_2 = ~clk_2;

  run_length_detector #(.RUN_LEN(2), .MAX_RUN(255)) u_a (
    .clk_2(clk_2), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
    .mode(mode), .clear(clear), .out_bit(out_bit[0]), .det_pulse(det_pulse[0]),
    .run_val(run_val[0]),
`ifdef RUN_DET_EVT_COUNT_EN
    .evt_count(evt[0]),
`endif
    .run_count(cnt0));

  run_length_detector #(.RUN_LEN(3), .MAX_RUN(255)) u_b (
    .clk_2(clk_2), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
    .mode(mode), .clear(clear), .out_bit(out_bit[1]), .det_pulse(det_pulse[1]),
    .run_val(run_val[1]),
`ifdef RUN_DET_EVT_COUNT_EN
    .evt_count(evt[1]),
`endif
    .run_count(cnt1));

  run_length_detector #(.RUN_LEN(2), .MAX_RUN(7)) u_c (
    .clk_2(clk_2), .reset_n(reset_n), .in_valid(in_valid), .in_bit(in_bit),
    .mode(mode), .clear(clear), .out_bit(out_bit[2]), .det_pulse(det_pulse[2]),
    .run_val(run_val[2]),
`ifdef RUN_DET_EVT_COUNT_EN
    .evt_count(evt[2]),
`endif
    .run_count(cnt2));

  always_comb begin
    cnt_all[0] = cnt0;
    cnt_all[1] = cnt1;
    cnt_all[2] = {5'd0, cnt2};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: length of the trailing run of equal accepted samples since reset/clear.
  int m_len[N];
  bit m_val[N];
  bit m_det[N];
  int m_evt[N];

  function automatic bit permits(input logic [1:0] m, input bit v);
    return (m == 2'b00) || (m == 2'b01 && !v) || (m == 2'b10 && v);
  endfunction

  always @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) begin
        m_len[i] = 0; m_val[i] = 0; m_det[i] = 0; m_evt[i] = 0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        m_det[i] = 0;
        if (clear) m_len[i] = 0;
        else if (in_valid) begin
          if (m_len[i] == 0 || in_bit != m_val[i]) begin
            m_val[i] = in_bit;
            m_len[i] = 1;
          end else m_len[i]++;
          if (m_len[i] == RL[i] && permits(mode, m_val[i])) begin
            m_det[i] = 1;
            m_evt[i] = (m_evt[i] + 1) % 256;
          end
        end
      end
    end
  end

  always @(negedge clk_2) begin
    for (int i = 0; i < N; i++) begin
      check($sformatf("cmp_cnt%0d", i), cnt_all[i],
            (m_len[i] > MR[i]) ? MR[i] : m_len[i]);
      check($sformatf("cmp_out%0d", i), out_bit[i],
            (m_len[i] >= RL[i] && permits(mode, m_val[i])) ? 1 : 0);
      check($sformatf("cmp_det%0d", i), det_pulse[i], m_det[i]);
      check($sformatf("cmp_val%0d", i), run_val[i], m_val[i]);
`ifdef RUN_DET_EVT_COUNT_EN
      check($sformatf("cmp_evt%0d", i), evt[i], m_evt[i]);
`endif
    end
  end

  task automatic step(input logic v, input logic b, input logic c);
    in_valid = v;
    in_bit   = b;
    clear    = c;
    @(posedge clk_2);
    #1;
  endtask

  int seq_b[7] = '{1, 1, 0, 1, 1, 1, 1};
  int det_b[7] = '{0, 0, 0, 0, 0, 1, 0};
  int vp[4]    = '{1, 0, 0, 1};
  int vp_cnt[4] = '{1, 1, 1, 2};
  int vp_det[4] = '{0, 0, 0, 1};
  int dets;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clear = 1'b0; mode = 2'b00;
    repeat (2) @(posedge clk_2);
    #1;
    check("rst_cnt", cnt0, 0);
    check("rst_out", out_bit[0], 0);
    check("rst_det", det_pulse[0], 0);
    check("rst_val", run_val[0], 0);
    #2 reset_n = 1'b1;

    // Legacy behaviour: two zeros detected with one cycle of latency.
    step(1, 0, 0);
    check("t1_cnt1", cnt0, 1);
    check("t1_out1", out_bit[0], 0);
    step(1, 0, 0);
    check("t1_cnt2", cnt0, 2);
    check("t1_out2", out_bit[0], 1);
    check("t1_det2", det_pulse[0], 1);
    check("t1_val2", run_val[0], 0);
    step(0, 0, 0);
    check("t1_det_once", det_pulse[0], 0);
    check("t1_hold", out_bit[0], 1);

    // RUN_LEN=3, ones only.
    step(0, 0, 1);
    mode = 2'b10;
    for (int k = 0; k < 7; k++) begin
      step(1, seq_b[k][0], 0);
      check($sformatf("t2_det%0d", k), det_pulse[1], det_b[k]);
      check($sformatf("t2_out%0d", k), out_bit[1], (k >= 5) ? 1 : 0);
    end
    check("t2_cnt", cnt1, 4);

    // Zeros-only mode suppresses a ones run; switching mode shows it without a pulse.
    step(0, 0, 1);
    mode = 2'b01;
    repeat (3) step(1, 1, 0);
    check("t3_out", out_bit[0], 0);
    check("t3_det", det_pulse[0], 0);
    check("t3_cnt", cnt0, 3);
    mode = 2'b00;
    #1;
    check("t3_out_mode", out_bit[0], 1);
    check("t3_det_mode", det_pulse[0], 0);

    // Gaps in in_valid hold state.
    step(0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      step(vp[k][0], 1, 0);
      check($sformatf("t4_cnt%0d", k), cnt0, vp_cnt[k]);
      check($sformatf("t4_det%0d", k), det_pulse[0], vp_det[k]);
    end

    // clear beats a simultaneous sample.
    step(0, 0, 1);
    repeat (5) step(1, 1, 0);
    check("t5_cnt5", cnt0, 5);
    step(1, 1, 1);
    check("t5_clr_cnt", cnt0, 0);
    check("t5_clr_out", out_bit[0], 0);
    step(1, 1, 0);
    check("t5_restart", cnt0, 1);

    // Saturation with MAX_RUN=7.
    step(0, 0, 1);
    dets = 0;
    repeat (12) begin
      step(1, 1, 0);
      dets += int'(det_pulse[2]);
    end
    check("t6_sat_cnt", cnt2, 7);
    check("t6_sat_out", out_bit[2], 1);
    check("t6_one_det", dets, 1);

    // Asynchronous reset mid-run.
    step(0, 0, 1);
    step(1, 1, 0);
    step(1, 1, 0);
    step(1, 1, 0);
    #2 reset_n = 1'b0;
    #1;
    check("t7_rst_cnt", cnt0, 0);
    check("t7_rst_out", out_bit[0], 0);
    check("t7_rst_det", det_pulse[0], 0);
    check("t7_rst_val", run_val[0], 0);
    in_valid = 1'b0;
    @(negedge clk_2);
    #2 reset_n = 1'b1;

    // 300 alternating-pair detections.
    mode = 2'b00;
    for (int k = 0; k < 300; k++) begin
      step(1, (k % 2 == 1), 0);
      step(1, (k % 2 == 1), 0);
    end
    check("t8_det_last", det_pulse[0], 1);
`ifdef RUN_DET_EVT_COUNT_EN
    check("t8_evt", evt[0], 44);
    step(0, 0, 1);
    check("t8_evt_clear", evt[0], 44);
`endif
    step(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
